// File: rtl/log2_pkg.sv
// Shared types and default parameters for the log2_frac base-2 logarithm unit.
package log2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        FRAC = 2'd2,
        DONE = 2'd3
    } log2_state_t;

    localparam int LOG2_N_DEF = 16;
    localparam int LOG2_F_DEF = 8;

endpackage

// File: rtl/log2_lod.sv
// Combinational leading-one detector: index of the highest set bit plus an all-zero flag.
module log2_lod #(
    parameter  int N = 16,
    localparam int M = $clog2(N)
) (
    input  logic [N-1:0] i_value,
    output logic [M-1:0] o_index,
    output logic         o_zero
);

    // Scan upward so the last set bit seen, the highest one, wins.
    always_comb begin
        o_index = '0;
        o_zero  = 1'b1;
        for (int i = 0; i < N; i++) begin
            o_index = i_value[i] ? M'(i) : o_index;
            o_zero  = i_value[i] ? 1'b0 : o_zero;
        end
    end

endmodule

// File: rtl/log2_frac.sv
// Multi-cycle log2 unit: integer part by leading-one search, F fraction bits by mantissa squaring.
// Optional macro LOG2_POW2_FLAG_EN adds the is_pow2 output.
module log2_frac
    import log2_pkg::*;
#(
    parameter  int N  = LOG2_N_DEF,
    parameter  int F  = LOG2_F_DEF,
    localparam int M  = $clog2(N),
    localparam int FW = (F > 0) ? F : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  value,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  result_int,
    output logic [FW-1:0] result_frac,
    output logic          err
`ifdef LOG2_POW2_FLAG_EN
    ,
    output logic          is_pow2
`endif
);

    // With F = 0 result_frac degenerates to a single bit tied to zero.
    localparam int CW = (F > 0) ? $clog2(F + 1) : 1;

    log2_state_t   r_state;
    log2_state_t   w_next_state;
    logic [N-1:0]  r_value;
    logic [N-1:0]  r_mant;
    logic [CW-1:0] r_cnt;
    logic [M-1:0]  r_int;
    logic [FW-1:0] r_frac;
    logic          r_err;

    logic [M-1:0]  w_lod_idx;
    logic          w_lod_zero;
    logic [M-1:0]  w_shamt;
    logic [N-1:0]  w_norm;
    logic [N:0]    w_top;
    logic          w_bit;
    logic [N-1:0]  w_next_mant;

    log2_lod #(.N(N)) u_lod (
        .i_value (r_value),
        .o_index (w_lod_idx),
        .o_zero  (w_lod_zero)
    );

    // Normalise to 1.(N-1) and square; w_top keeps product bits 2N-1 down to N-1.
    always_comb begin
        w_shamt     = M'(N - 1) - w_lod_idx;
        w_norm      = r_value << w_shamt;
        w_top       = (N + 1)'((((2 * N))'(r_mant) * ((2 * N))'(r_mant)) >> (N - 1));
        w_bit       = w_top[N];
        w_next_mant = w_bit ? w_top[N:1] : w_top[N-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = in_valid ? NORM : IDLE;
            NORM:    w_next_state = (w_lod_zero || (F == 0)) ? DONE : FRAC;
            FRAC:    w_next_state = (r_cnt == '0) ? DONE : FRAC;
            DONE:    w_next_state = out_ready ? IDLE : DONE;
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Operand capture, normalisation and one fraction bit per FRAC cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value <= '0;
            r_mant  <= '0;
            r_cnt   <= '0;
            r_int   <= '0;
            r_frac  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_value <= value;
                        r_int   <= '0;
                        r_frac  <= '0;
                        r_err   <= 1'b0;
                    end
                end
                NORM: begin
                    r_int  <= w_lod_idx;
                    r_err  <= w_lod_zero;
                    r_mant <= w_norm;
                    r_cnt  <= CW'(F);
                    r_frac <= '0;
                end
                FRAC: begin
                    if (r_cnt != '0) begin
                        r_frac <= FW'({r_frac, w_bit});
                        r_mant <= w_next_mant;
                        r_cnt  <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign result_int  = r_int;
    assign result_frac = r_frac;
    assign err         = r_err;

`ifdef LOG2_POW2_FLAG_EN
    logic r_pow2;

    function automatic logic onehot(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    // Power-of-two flag, registered alongside result_int.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pow2 <= 1'b0;
        end else if ((r_state == IDLE) && in_valid) begin
            r_pow2 <= 1'b0;
        end else if (r_state == NORM) begin
            r_pow2 <= onehot(r_value);
        end
    end

    assign is_pow2 = r_pow2;
`endif

endmodule

// File: tb/tb_log2_frac.sv
// Self-checking bench for log2_frac with N=8, F=4 (optionally with LOG2_POW2_FLAG_EN).
module tb_log2_frac;

    localparam int N = 8;
    localparam int F = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] value;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] result_int;
    logic [3:0] result_frac;
    logic       err;
`ifdef LOG2_POW2_FLAG_EN
    logic       is_pow2;
`endif

    log2_frac #(.N(N), .F(F)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .value       (value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result_int  (result_int),
        .result_frac (result_frac),
        .err         (err)
`ifdef LOG2_POW2_FLAG_EN
        ,
        .is_pow2     (is_pow2)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int e_int;
    int e_frac;
    bit e_err;
    bit e_p2;
    bit exp_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: floor(log2) by counting, fraction by squaring a scaled mantissa.
    function automatic void model(input int v, output int mi, output int mf, output bit me, output bit mp);
        longint one;
        longint mant;
        longint sq;
        mi = 0;
        mf = 0;
        me = 1'b0;
        mp = 1'b0;
        if (v == 0) begin
            me = 1'b1;
        end else begin
            while ((v >> (mi + 1)) != 0) mi++;
            mp   = (v == (1 << mi));
            one  = 64'd1 << (N - 1);
            mant = longint'(v) << (N - 1 - mi);
            for (int k = 0; k < F; k++) begin
                sq = mant * mant;
                if (sq >= 2 * one * one) begin
                    mf   = mf * 2 + 1;
                    mant = sq >> N;
                end else begin
                    mf   = mf * 2;
                    mant = sq >> (N - 1);
                end
            end
        end
    endfunction

    // Compare process: every cycle a result is presented, it must match the model.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1) begin
            if (!exp_valid) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                chk("result_int", result_int, e_int);
                chk("result_frac", result_frac, e_frac);
                chk("err", err, e_err);
`ifdef LOG2_POW2_FLAG_EN
                chk("is_pow2", is_pow2, e_p2);
`endif
            end
        end
    end

    // Offer v, pin the model to hand-computed literals, wait for DONE and check the latency.
    task automatic start_op(input int v, input int li, input int lf, input int le, input int lp, input int lat);
        int mi;
        int mf;
        bit me;
        bit mp;
        int n;
        bit rdy;
        bit acc;
        model(v, mi, mf, me, mp);
        chk("model_int", mi, li);
        chk("model_frac", mf, lf);
        chk("model_err", me, le);
        chk("model_pow2", mp, lp);
        e_int     = mi;
        e_frac    = mf;
        e_err     = me;
        e_p2      = mp;
        exp_valid = 1'b1;
        in_valid  = 1'b1;
        value     = v[7:0];
        acc       = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) acc = 1'b1;
            else @(negedge clk);
        end
        chk("accept", acc, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("busy_in_ready", in_ready, 0);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("latency", n, lat);
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        exp_valid = 1'b0;
        chk("handoff_out_valid", out_valid, 0);
        chk("handoff_in_ready", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        value     = 8'd0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result_int", result_int, 0);
        chk("rst_result_frac", result_frac, 0);
        chk("rst_err", err, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed vectors: value, int, frac, err, pow2, latency.
        start_op(8,   3, 0,  0, 1, F + 2); finish_op();
        start_op(3,   1, 9,  0, 0, F + 2); finish_op();
        start_op(255, 7, 15, 0, 0, F + 2); finish_op();
        start_op(1,   0, 0,  0, 1, F + 2); finish_op();
        start_op(0,   0, 0,  1, 0, 1);     finish_op();

        // Backpressure with a new operand waiting: not accepted until after the handoff.
        start_op(3, 1, 9, 0, 0, F + 2);
        in_valid = 1'b1;
        value    = 8'd200;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        finish_op();
        start_op(200, 7, 10, 0, 0, F + 2); finish_op();

        // Reset pulse while the fraction is being computed.
        in_valid = 1'b1;
        value    = 8'd255;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_busy", in_ready, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_result_int", result_int, 0);
        chk("mid_rst_result_frac", result_frac, 0);
        chk("mid_rst_err", err, 0);
`ifdef LOG2_POW2_FLAG_EN
        chk("mid_rst_is_pow2", is_pow2, 0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start_op(16, 4, 0, 0, 1, F + 2); finish_op();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
